alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq.sv | 94 +++++++++
 tb/tb_alu_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for alu_seq: opcodes, external ALU select codes and FSM state encoding.
package alu_seq_pkg;

    typedef logic [2:0] op_t;
    typedef logic [1:0] sel_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_LOAD  = 3'b000;
    localparam op_t OP_ADD   = 3'b001;
    localparam op_t OP_NOTB  = 3'b010;
    localparam op_t OP_AND   = 3'b011;
    localparam op_t OP_OR    = 3'b100;
    localparam op_t OP_STORE = 3'b101;
    localparam op_t OP_CLR   = 3'b110;
    localparam op_t OP_RSVD  = 3'b111;

    localparam sel_t SEL_ADD  = 2'b00;
    localparam sel_t SEL_NOTB = 2'b01;
    localparam sel_t SEL_AND  = 2'b10;
    localparam sel_t SEL_OR   = 2'b11;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_OUT   = 2'd2;

    // Map an ALU opcode onto the external ALU select code.
    function automatic sel_t op_to_sel(input op_t op);
        case (op)
            OP_NOTB: return SEL_NOTB;
            OP_AND:  return SEL_AND;
            OP_OR:   return SEL_OR;
            default: return SEL_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command, external ALU and result signals of alu_seq bundled as one interface.
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic        cmd_valid;
    op_t         cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_ready;

    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    sel_t        alu_sel;
    logic [7:0]  alu_f;
    logic        alu_ovf;

    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ovf;
    logic        res_ready;
    logic [7:0]  op_count;

    // Environment side: issues commands, hosts the ALU, consumes results.
    modport master (
        output cmd_valid, cmd_op, cmd_data, alu_f, alu_ovf, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_ovf, op_count
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, alu_f, alu_ovf, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_ovf, op_count
    );

endinterface

// File: rtl/alu_seq.sv
// Accumulator sequencer driving an external 8-bit ALU: issue/capture in two edges,
// sticky add-overflow, saturating op counter and a held result output.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    state_t     state;
    logic [7:0] acc;
    logic       sticky_ovf;
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    sel_t       alu_sel_q;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic       res_ovf_q;
    logic [7:0] op_count_q;

    // Commands are only taken in IDLE; reset forces ready low combinationally.
    assign bus.cmd_ready = (state == ST_IDLE) && !rst;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.op_count  = op_count_q;

    // Command accept, ALU result capture and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            sticky_ovf  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= SEL_ADD;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_LOAD: acc <= bus.cmd_data;
                            OP_ADD, OP_NOTB, OP_AND, OP_OR: begin
                                alu_a_q   <= acc;
                                alu_b_q   <= bus.cmd_data;
                                alu_sel_q <= op_to_sel(bus.cmd_op);
                                state     <= ST_ISSUE;
                            end
                            OP_STORE: begin
                                res_data_q  <= acc;
                                res_ovf_q   <= sticky_ovf;
                                res_valid_q <= 1'b1;
                                state       <= ST_OUT;
                            end
                            OP_CLR: begin
                                acc        <= '0;
                                sticky_ovf <= 1'b0;
                                op_count_q <= '0;
                            end
                            default: ; // reserved opcode is consumed with no effect
                        endcase
                    end
                end
                ST_ISSUE: begin
                    // alu_sel still holds the issued op, so it tells us whether overflow counts
                    acc <= bus.alu_f;
                    if (alu_sel_q == SEL_ADD) begin
                        sticky_ovf <= sticky_ovf | bus.alu_ovf;
                    end
                    if (op_count_q != 8'hFF) begin
                        op_count_q <= op_count_q + 8'd1;
                    end
                    state <= ST_IDLE;
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written corner
// sequences and randomized commands against an arithmetic accumulator model.
module tb_alu_seq;

    localparam logic [2:0] L_LOAD  = 3'b000;
    localparam logic [2:0] L_ADD   = 3'b001;
    localparam logic [2:0] L_NOTB  = 3'b010;
    localparam logic [2:0] L_AND   = 3'b011;
    localparam logic [2:0] L_OR    = 3'b100;
    localparam logic [2:0] L_STORE = 3'b101;
    localparam logic [2:0] L_CLR   = 3'b110;
    localparam logic [2:0] L_RSVD  = 3'b111;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       chk_alu;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] esel;
        logic       chk_res;
        logic [7:0] erd;
        logic       eovf;
        logic [7:0] ecnt;
    } vec_t;

    localparam int NV = 18;

    logic clk;
    logic rst;
    logic [7:0] alu_sum;
    int unsigned n_checks;
    int unsigned n_fail;
    vec_t vecs [NV];

    alu_seq_if bus ();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; overflow is deliberately high for non-add ops so the sequencer must ignore it.
    assign alu_sum = bus.alu_a + bus.alu_b;
    always_comb begin
        bus.alu_f   = 8'h00;
        bus.alu_ovf = 1'b1;
        case (bus.alu_sel)
            2'b00: begin
                bus.alu_f   = alu_sum;
                bus.alu_ovf = (bus.alu_a[7] == bus.alu_b[7]) && (alu_sum[7] != bus.alu_a[7]);
            end
            2'b01: bus.alu_f = ~bus.alu_b;
            2'b10: bus.alu_f = bus.alu_a & bus.alu_b;
            default: bus.alu_f = bus.alu_a | bus.alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v_cmd(input logic [2:0] op, input logic [7:0] d);
        vec_t v;
        v = '{op, d, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00};
        return v;
    endfunction

    function automatic vec_t v_alu(input logic [2:0] op, input logic [7:0] d,
                                   input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] es);
        vec_t v;
        v = '{op, d, 1'b1, ea, eb, es, 1'b0, 8'h00, 1'b0, 8'h00};
        return v;
    endfunction

    function automatic vec_t v_st(input logic [7:0] erd, input logic eovf, input logic [7:0] ecnt);
        vec_t v;
        v = '{L_STORE, 8'h00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, erd, eovf, ecnt};
        return v;
    endfunction

    // Present one command at a falling edge once ready, return 1ns after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int unsigned w;
        w = 0;
        @(negedge clk);
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Check the held result after a STORE accept, optionally stall, then complete the handshake.
    task automatic finish_store(input logic [7:0] ed, input logic eo, input logic [7:0] ec,
                                input int unsigned hold);
        check("res_valid_set", 32'(bus.res_valid), 32'd1);
        check("res_data", 32'(bus.res_data), 32'(ed));
        check("res_ovf", 32'(bus.res_ovf), 32'(eo));
        check("op_count", 32'(bus.op_count), 32'(ec));
        check("cmd_ready_out", 32'(bus.cmd_ready), 32'd0);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("res_data_hold", 32'(bus.res_data), 32'(ed));
            check("res_valid_hold", 32'(bus.res_valid), 32'd1);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("res_valid_clr", 32'(bus.res_valid), 32'd0);
        check("cmd_ready_after_out", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned m_acc;
        int unsigned m_cnt;
        logic        m_sticky;
        int          sa;
        int          sb;
        logic [2:0]  op;
        logic [7:0]  d;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'h00;
        bus.res_ready = 1'b0;

        vecs[0]  = v_cmd(L_LOAD, 8'h07);
        vecs[1]  = v_alu(L_ADD, 8'h64, 8'h07, 8'h64, 2'b00);
        vecs[2]  = v_st(8'h6B, 1'b0, 8'd1);
        vecs[3]  = v_cmd(L_LOAD, 8'h50);
        vecs[4]  = v_alu(L_ADD, 8'h5A, 8'h50, 8'h5A, 2'b00);
        vecs[5]  = v_st(8'hAA, 1'b1, 8'd2);
        vecs[6]  = v_cmd(L_CLR, 8'h00);
        vecs[7]  = v_st(8'h00, 1'b0, 8'd0);
        vecs[8]  = v_cmd(L_LOAD, 8'h0F);
        vecs[9]  = v_alu(L_NOTB, 8'h5A, 8'h0F, 8'h5A, 2'b01);
        vecs[10] = v_st(8'hA5, 1'b0, 8'd1);
        vecs[11] = v_alu(L_AND, 8'h95, 8'hA5, 8'h95, 2'b10);
        vecs[12] = v_st(8'h85, 1'b0, 8'd2);
        vecs[13] = v_alu(L_OR, 8'h0F, 8'h85, 8'h0F, 2'b11);
        vecs[14] = v_st(8'h8F, 1'b0, 8'd3);
        vecs[15] = v_cmd(L_RSVD, 8'hFF);
        vecs[16] = v_st(8'h8F, 1'b0, 8'd3);
        vecs[17] = v_cmd(L_LOAD, 8'h8F);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_ovf", 32'(bus.res_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].op, vecs[i].data);
            if (vecs[i].chk_alu) begin
                check("tbl_alu_a", 32'(bus.alu_a), 32'(vecs[i].ea));
                check("tbl_alu_b", 32'(bus.alu_b), 32'(vecs[i].eb));
                check("tbl_alu_sel", 32'(bus.alu_sel), 32'(vecs[i].esel));
                check("tbl_issue_busy", 32'(bus.cmd_ready), 32'd0);
            end
            if (vecs[i].chk_res) begin
                finish_store(vecs[i].erd, vecs[i].eovf, vecs[i].ecnt, 0);
            end
        end

        // Result stall: commands offered during OUT must be ignored
        send(L_LOAD, 8'h3C);
        send(L_STORE, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = L_LOAD;
            bus.cmd_data  = 8'hFF;
            @(posedge clk);
            #1;
            check("stall_res_valid", 32'(bus.res_valid), 32'd1);
            check("stall_res_data", 32'(bus.res_data), 32'h3C);
            check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        check("stall_release_valid", 32'(bus.res_valid), 32'd0);
        check("stall_release_ready", 32'(bus.cmd_ready), 32'd1);
        send(L_STORE, 8'h00);
        finish_store(8'h3C, 1'b0, 8'd3, 0);

        // Reset during ISSUE discards the capture
        send(L_LOAD, 8'h20);
        send(L_ADD, 8'h10);
        check("issue_busy", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_issue_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("rst_issue_op_count", 32'(bus.op_count), 32'd0);
        check("rst_issue_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_issue_alu_b", 32'(bus.alu_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_issue_ready_after", 32'(bus.cmd_ready), 32'd1);
        send(L_STORE, 8'h00);
        finish_store(8'h00, 1'b0, 8'd0, 0);

        // Reset during OUT drops the pending result
        send(L_LOAD, 8'h55);
        send(L_STORE, 8'h00);
        check("out_pending", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_out_res_data", 32'(bus.res_data), 32'd0);
        check("rst_out_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_ready_after", 32'(bus.cmd_ready), 32'd1);
        send(L_STORE, 8'h00);
        finish_store(8'h00, 1'b0, 8'd0, 0);

        // 300 back-to-back ADD 1: ready toggles, counter saturates, acc wraps to 0x2C
        send(L_CLR, 8'h00);
        begin
            int unsigned accepts;
            int unsigned bad;
            logic        exp_r;
            accepts = 0;
            bad     = 0;
            bus.cmd_op   = L_ADD;
            bus.cmd_data = 8'h01;
            for (int cyc = 0; cyc < 1000 && accepts < 300; cyc++) begin
                @(negedge clk);
                bus.cmd_valid = 1'b1;
                exp_r = ((cyc % 2) == 0);
                if (bus.cmd_ready !== exp_r) bad++;
                if (bus.cmd_ready) accepts++;
            end
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            check("b2b_ready_pattern", bad, 32'd0);
            check("b2b_accepts", accepts, 32'd300);
        end
        send(L_STORE, 8'h00);
        finish_store(8'h2C, 1'b1, 8'd255, 0);

        // Randomized commands against an arithmetic model
        send(L_CLR, 8'h00);
        m_acc    = 0;
        m_cnt    = 0;
        m_sticky = 1'b0;
        for (int n = 0; n < 250; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op == L_CLR && $urandom_range(0, 7) != 0) op = L_ADD;
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(op, d);
            case (op)
                L_ADD, L_NOTB, L_AND, L_OR: begin
                    check("rnd_alu_a", 32'(bus.alu_a), m_acc);
                    check("rnd_alu_b", 32'(bus.alu_b), 32'(d));
                    check("rnd_alu_sel", 32'(bus.alu_sel), 32'(op) - 1);
                    if (op == L_ADD) begin
                        sa = (m_acc >= 128) ? int'(m_acc) - 256 : int'(m_acc);
                        sb = (d >= 128) ? int'(d) - 256 : int'(d);
                        if (sa + sb > 127 || sa + sb < -128) m_sticky = 1'b1;
                        m_acc = (m_acc + d) % 256;
                    end else if (op == L_NOTB) begin
                        m_acc = 255 - d;
                    end else if (op == L_AND) begin
                        m_acc = m_acc & d;
                    end else begin
                        m_acc = m_acc | d;
                    end
                    if (m_cnt < 255) m_cnt++;
                    @(posedge clk);
                    #1;
                    check("rnd_op_count", 32'(bus.op_count), m_cnt);
                    check("rnd_capture_ready", 32'(bus.cmd_ready), 32'd1);
                end
                L_STORE: finish_store(8'(m_acc), m_sticky, 8'(m_cnt), $urandom_range(0, 3));
                default: begin
                    if (op == L_LOAD) m_acc = d;
                    if (op == L_CLR) begin
                        m_acc    = 0;
                        m_cnt    = 0;
                        m_sticky = 1'b0;
                    end
                    check("rnd_idle_ready", 32'(bus.cmd_ready), 32'd1);
                    check("rnd_idle_count", 32'(bus.op_count), m_cnt);
                end
            endcase
        end
        send(L_STORE, 8'h00);
        finish_store(8'(m_acc), m_sticky, 8'(m_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
